// File: rtl/quad_decoder.sv
// ---------------------------------------------------------------------------
// quad_decoder
//   Debounced quadrature decoder. Each encoder channel passes through a 2-flop
//   synchronizer and then a per-channel debounce filter. Every legal Gray-code
//   step of the filtered pair adds +1 or -1 to a signed accumulator. When the
//   accumulator reaches +DIV or -DIV, a one-cycle move command is issued and
//   the accumulator is cleared. A step that changes both filtered bits at once
//   is illegal: it raises err for one cycle and bumps a saturating counter.
//
// Parameters
//   DEBOUNCE : cycles a synced level must differ from its filtered level
//              before it is accepted (1..255)
//   DIV      : quarter-steps per move pulse (1, 2 or 4)
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous active-high reset
//   enc_a    in   encoder channel A (asynchronous)
//   enc_b    in   encoder channel B (asynchronous)
//   move     out  2'b10 = step CW, 2'b01 = step CCW, 2'b00 = idle (one cycle)
//   err      out  one-cycle pulse on an illegal filtered transition
//   err_cnt  out  saturating count of err pulses
// ---------------------------------------------------------------------------
module quad_decoder #(
    parameter int DEBOUNCE = 4,
    parameter int DIV      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_a,
    input  logic       enc_b,
    output logic [1:0] move,
    output logic       err,
    output logic [7:0] err_cnt
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [7:0]        DB_LAST = 8'(DEBOUNCE - 1);
    localparam logic signed [3:0] DIV_POS = 4'(DIV);
    localparam logic signed [3:0] DIV_NEG = -DIV_POS;

    state_t            state_reg, state_next;
    logic [1:0]        init_cnt_reg;
    logic              load;

    // Bit 1 is channel A, bit 0 is channel B, so filt reads as {fa,fb}.
    logic [1:0]        enc_pair;
    logic [1:0]        sync_pair;
    logic [1:0]        filt_pair;
    logic [1:0]        prev_pair_reg;

    logic              step_fwd;
    logic              step_back;
    logic              step_bad;
    logic signed [3:0] step;
    logic signed [3:0] acc_reg;
    logic signed [3:0] acc_sum;

    assign enc_pair = {enc_a, enc_b};

    // The third edge after reset release loads the filter and starts RUN.
    assign load = (state_reg == INIT) && (init_cnt_reg == 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= INIT;
            init_cnt_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == INIT && init_cnt_reg != 2'd2)
                init_cnt_reg <= init_cnt_reg + 2'd1;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (load)
            state_next = RUN;
    end

    // Per-channel synchronizer and debounce filter.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic       s1_reg;
            logic       s2_reg;
            logic       filt_reg;
            logic [7:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= enc_pair[gi];
                    s2_reg <= s1_reg;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    filt_reg <= 1'b0;
                    cnt_reg  <= 8'd0;
                end else if (state_reg == INIT) begin
                    cnt_reg <= 8'd0;
                    if (load)
                        filt_reg <= s2_reg;
                end else if (s2_reg != filt_reg) begin
                    if (cnt_reg == DB_LAST) begin
                        filt_reg <= s2_reg;
                        cnt_reg  <= 8'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end else begin
                    cnt_reg <= 8'd0;
                end
            end

            assign sync_pair[gi] = s2_reg;
            assign filt_pair[gi] = filt_reg;
        end
    endgenerate

    // Classify the filtered-pair change seen in the previous cycle.
    always_comb begin
        step_fwd  = 1'b0;
        step_back = 1'b0;
        step_bad  = 1'b0;
        case ({prev_pair_reg, filt_pair})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_fwd  = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_back = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: step_bad  = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        step = 4'sd0;
        if (step_fwd)
            step = 4'sd1;
        else if (step_back)
            step = -4'sd1;
    end

    assign acc_sum = acc_reg + step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_pair_reg <= 2'b00;
            acc_reg       <= 4'sd0;
            move          <= 2'b00;
            err           <= 1'b0;
            err_cnt       <= 8'd0;
        end else begin
            move <= 2'b00;
            err  <= 1'b0;
            // While the filter is being loaded, track the loaded value so the
            // first RUN cycle sees no change (pins held at 11 are not an error).
            prev_pair_reg <= (state_reg == INIT) ? sync_pair : filt_pair;
            if (state_reg == RUN) begin
                if (step_bad) begin
                    err <= 1'b1;
                    if (err_cnt != 8'hFF)
                        err_cnt <= err_cnt + 8'd1;
                end else if (step_fwd || step_back) begin
                    if (acc_sum == DIV_POS) begin
                        move    <= 2'b10;
                        acc_reg <= 4'sd0;
                    end else if (acc_sum == DIV_NEG) begin
                        move    <= 2'b01;
                        acc_reg <= 4'sd0;
                    end else begin
                        acc_reg <= acc_sum;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// ---------------------------------------------------------------------------
// tb_quad_decoder
//   Two decoders (DIV=4 and DIV=1, both DEBOUNCE=4) share the encoder pins.
//   A reference model tracks the pins as a sequence of held levels. It turns
//   each accepted level into a Gray position 0..3, derives quarter-steps and
//   illegal jumps with modular arithmetic, and accumulates expected pulse
//   totals. A negedge monitor counts observed pulses and checks the output
//   protocol every cycle.
// ---------------------------------------------------------------------------
module tb_quad_decoder;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       enc_a;
    logic       enc_b;
    logic [1:0] move4, move1;
    logic       err4, err1;
    logic [7:0] ecnt4, ecnt1;

    always #5 clk = ~clk;

    quad_decoder #(.DEBOUNCE(DEB), .DIV(4)) u_div4 (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
        .move(move4), .err(err4), .err_cnt(ecnt4)
    );

    quad_decoder #(.DEBOUNCE(DEB), .DIV(1)) u_div1 (
        .clk(clk), .rst(rst), .enc_a(enc_a), .enc_b(enc_b),
        .move(move1), .err(err1), .err_cnt(ecnt1)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- monitor ----------------
    int inc4 = 0, dec4 = 0, errp4 = 0;
    int inc1 = 0, dec1 = 0, errp1 = 0;
    logic [1:0] pm4 = 2'b00, pm1 = 2'b00;
    logic       pe4 = 1'b0, pe1 = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (move4 == 2'b10) inc4++;
            if (move4 == 2'b01) dec4++;
            if (err4) errp4++;
            if (move1 == 2'b10) inc1++;
            if (move1 == 2'b01) dec1++;
            if (err1) errp1++;
            check("protocol_div4",
                  int'((move4 == 2'b11) || (move4 != 2'b00 && err4) ||
                       (move4 != 2'b00 && pm4 != 2'b00) || (err4 && pe4)), 0);
            check("protocol_div1",
                  int'((move1 == 2'b11) || (move1 != 2'b00 && err1) ||
                       (move1 != 2'b00 && pm1 != 2'b00) || (err1 && pe1)), 0);
        end
        pm4 = move4;
        pm1 = move1;
        pe4 = err4;
        pe1 = err1;
    end

    // ---------------- reference model ----------------
    int         acc4 = 0, acc1 = 0;
    int         exp_inc4 = 0, exp_dec4 = 0, exp_inc1 = 0, exp_dec1 = 0;
    int         exp_err = 0, exp_ecnt = 0;
    logic [1:0] mfilt = 2'b00;

    function automatic int gpos(input logic [1:0] lvl);
        case (lvl)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic void acc_step(input int div, input int stp,
                                     inout int acc, inout int inc, inout int dec);
        acc += stp;
        if (acc == div) begin
            inc++;
            acc = 0;
        end else if (acc == -div) begin
            dec++;
            acc = 0;
        end
    endfunction

    task automatic model_accept(input logic [1:0] lvl);
        int d;
        if (lvl == mfilt) return;
        d = (gpos(lvl) - gpos(mfilt) + 4) % 4;
        if (d == 2) begin
            exp_err++;
            if (exp_ecnt < 255) exp_ecnt++;
        end else begin
            acc_step(4, (d == 1) ? 1 : -1, acc4, exp_inc4, exp_dec4);
            acc_step(1, (d == 1) ? 1 : -1, acc1, exp_inc1, exp_dec1);
        end
        mfilt = lvl;
    endtask

    // ---------------- stimulus helpers ----------------
    // Present lvl on the pins for exactly 'hold' rising edges.
    task automatic drive(input logic [1:0] lvl, input int hold);
        @(negedge clk);
        {enc_a, enc_b} = lvl;
        repeat (hold - 1) @(negedge clk);
        if (hold >= DEB) model_accept(lvl);
    endtask

    task automatic settle();
        repeat (12) @(negedge clk);
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_inc4"}, inc4, exp_inc4);
        check({tag, "_dec4"}, dec4, exp_dec4);
        check({tag, "_inc1"}, inc1, exp_inc1);
        check({tag, "_dec1"}, dec1, exp_dec1);
        check({tag, "_err4"}, errp4, exp_err);
        check({tag, "_err1"}, errp1, exp_err);
        check({tag, "_ecnt4"}, int'(ecnt4), exp_ecnt);
        check({tag, "_ecnt1"}, int'(ecnt1), exp_ecnt);
    endtask

    task automatic do_reset(input logic [1:0] lvl, input int cycles);
        @(negedge clk);
        rst = 1'b1;
        {enc_a, enc_b} = lvl;
        repeat (cycles) @(negedge clk);
        check("rst_move4", int'(move4), 0);
        check("rst_move1", int'(move1), 0);
        check("rst_err4", int'(err4), 0);
        check("rst_err1", int'(err1), 0);
        check("rst_ecnt4", int'(ecnt4), 0);
        check("rst_ecnt1", int'(ecnt1), 0);
        rst = 1'b0;
        acc4     = 0;
        acc1     = 0;
        exp_ecnt = 0;
        mfilt    = lvl;
        repeat (20) @(negedge clk);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst   = 1'b1;
        enc_a = 1'b0;
        enc_b = 1'b0;
        do_reset(2'b00, 4);
        compare_all("after_reset");

        // One full CW cycle.
        drive(2'b01, 20);
        drive(2'b11, 20);
        drive(2'b10, 20);
        drive(2'b00, 20);
        settle();
        compare_all("cw_cycle");
        check("cw_cycle_one_pulse", inc4, 1);

        // Eight CCW quarter-steps.
        for (int r = 0; r < 2; r++) begin
            drive(2'b10, 20);
            drive(2'b11, 20);
            drive(2'b01, 20);
            drive(2'b00, 20);
        end
        settle();
        compare_all("ccw8");
        check("ccw8_div1_dec", dec1, 8);

        // Glitch shorter than DEBOUNCE is rejected; a 5-cycle pulse is taken.
        drive(2'b10, 3);
        drive(2'b00, 20);
        settle();
        compare_all("glitch3");
        drive(2'b10, 5);
        drive(2'b00, 20);
        settle();
        compare_all("pulse5");

        // Both channels together: illegal jump, then saturate the counter.
        drive(2'b11, 20);
        settle();
        compare_all("double_jump");
        check("double_jump_ecnt", int'(ecnt4), 1);
        for (int i = 0; i < 300; i++)
            drive((i % 2 == 0) ? 2'b00 : 2'b11, 20);
        settle();
        compare_all("err_sat");
        check("err_sat_ecnt", int'(ecnt4), 255);

        // Random legal/illegal level sequence, every level held >= DEBOUNCE.
        for (int i = 0; i < 60; i++) begin
            drive(2'($urandom_range(0, 3)), int'($urandom_range(DEB + 1, 24)));
            if (i % 15 == 14) begin
                settle();
                compare_all("random");
            end
        end

        // Partial accumulation discarded by reset; pins held at 11 through release.
        do_reset(2'b10, 3);
        drive(2'b00, 20);
        drive(2'b01, 20);
        drive(2'b11, 20);
        settle();
        compare_all("partial3");
        do_reset(2'b11, 2);
        compare_all("hold11_release");
        drive(2'b10, 20);
        compare_all("after_rst_q1");
        drive(2'b00, 20);
        compare_all("after_rst_q2");
        drive(2'b01, 20);
        compare_all("after_rst_q3");
        drive(2'b11, 20);
        settle();
        compare_all("after_rst_q4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
